// File: rtl/exception_ctrl.sv
// Exception/rfe sequencer for next-PC selection: saves EPC, fetches the handler vector byte, redirects PC.
// Latency: exception -> pc_write after 2+MEM_LAT cycles; rfe -> pc_write next cycle; new requests ignored while busy.
module exception_ctrl #(
   parameter int VEC_BASE = 253,
   parameter int MEM_LAT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_opcode,
   input  logic        exc_ovf,
   input  logic        exc_div0,
   input  logic        rfe,
   input  logic [31:0] pc_in,
   input  logic [31:0] mem_data_in,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic [31:0] epc_out,
   output logic [1:0]  cause_out,
   output logic [2:0]  pcsource,
   output logic        pc_write,
   output logic        busy
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SAVE  = 3'd1,
      FETCH = 3'd2,
      LOAD  = 3'd3,
      RET   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   epc_q, epc_d;
   logic [31:0]   addr_q, addr_d;
   logic [1:0]    cause_q, cause_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          any_exc;

   assign any_exc = exc_opcode | exc_ovf | exc_div0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         epc_q   <= '0;
         addr_q  <= '0;
         cause_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         addr_q  <= addr_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      addr_d  = addr_q;
      cause_d = cause_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            // Exception beats a simultaneous rfe; the rfe is simply dropped.
            if (any_exc) begin
               state_d = SAVE;
               cause_d = exc_opcode ? 2'd0 : (exc_ovf ? 2'd1 : 2'd2);
            end else if (rfe) begin
               state_d = RET;
            end
         end
         SAVE: begin
            epc_d   = pc_in - 32'd4;
            addr_d  = 32'(VEC_BASE) + {30'd0, cause_q};
            cnt_d   = CNT_INIT;
            state_d = FETCH;
         end
         FETCH: begin
            if (cnt_q == '0) state_d = LOAD;
            else             cnt_d   = cnt_q - 1'b1;
         end
         LOAD:    state_d = IDLE;
         RET:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_read = 1'b0;
      pcsource = 3'b000;
      pc_write = 1'b0;
      busy     = (state_q != IDLE);
      unique case (state_q)
         FETCH: mem_read = 1'b1;
         LOAD: begin
            pcsource = 3'b100;
            pc_write = 1'b1;
         end
         RET: begin
            pcsource = 3'b001;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign mem_addr  = addr_q;
   assign epc_out   = epc_q;
   assign cause_out = cause_q;

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        exc_opcode, exc_ovf, exc_div0, rfe;
   logic [31:0] pc_in, mem_data_in;
   logic [31:0] mem_addr, epc_out;
   logic        mem_read, pc_write, busy;
   logic [1:0]  cause_out;
   logic [2:0]  pcsource;

   int n_asrt = 0;
   int n_fail = 0;
   int pw_cnt = 0;

   always #5 clk = ~clk;

   exception_ctrl #(.VEC_BASE(253), .MEM_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0), .rfe(rfe),
      .pc_in(pc_in), .mem_data_in(mem_data_in),
      .mem_addr(mem_addr), .mem_read(mem_read), .epc_out(epc_out),
      .cause_out(cause_out), .pcsource(pcsource), .pc_write(pc_write), .busy(busy)
   );

   // Advance one cycle, observing at the falling edge; counts pc_write strobes.
   task automatic step();
      @(negedge clk);
      if (pc_write) pw_cnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_pcw"},  32'(pc_write), 32'd0);
      chk({tag, "_psrc"}, 32'(pcsource), 32'd0);
      chk({tag, "_mrd"},  32'(mem_read), 32'd0);
   endtask

   initial begin
      int pw_start;
      reset = 1'b1; exc_opcode = 0; exc_ovf = 0; exc_div0 = 0; rfe = 0;
      pc_in = '0; mem_data_in = '0;
      step(); step();
      reset = 1'b0;
      step();
      chk_idle("rst");
      chk("rst_epc",   epc_out, 32'd0);
      chk("rst_addr",  mem_addr, 32'd0);
      chk("rst_cause", 32'(cause_out), 32'd0);

      // 1: overflow exception
      exc_ovf = 1; pc_in = 32'h108; mem_data_in = 32'h40; pw_start = pw_cnt;
      step(); exc_ovf = 0;
      chk("t1_save_busy", 32'(busy), 32'd1);
      chk("t1_save_cause", 32'(cause_out), 32'd1);
      chk("t1_save_mrd", 32'(mem_read), 32'd0);
      chk("t1_save_pcw", 32'(pc_write), 32'd0);
      step();
      chk("t1_fetch_epc", epc_out, 32'h104);
      chk("t1_fetch_addr", mem_addr, 32'd254);
      chk("t1_fetch_mrd", 32'(mem_read), 32'd1);
      chk("t1_fetch_pcw", 32'(pc_write), 32'd0);
      step();
      chk("t1_load_mrd", 32'(mem_read), 32'd0);
      chk("t1_load_psrc", 32'(pcsource), 32'd4);
      chk("t1_load_pcw", 32'(pc_write), 32'd1);
      step();
      chk_idle("t1_end");
      chk("t1_end_addr", mem_addr, 32'd254);
      chk("t1_pw_count", 32'(pw_cnt - pw_start), 32'd1);

      // 3: rfe with EPC = 0x104
      rfe = 1;
      step(); rfe = 0;
      chk("t3_psrc", 32'(pcsource), 32'd1);
      chk("t3_pcw", 32'(pc_write), 32'd1);
      chk("t3_busy", 32'(busy), 32'd1);
      chk("t3_epc", epc_out, 32'h104);
      step();
      chk_idle("t3_end");
      chk("t3_epc_hold", epc_out, 32'h104);

      // 2: opcode and div0 together -> opcode priority
      exc_opcode = 1; exc_div0 = 1; pc_in = 32'h200;
      step(); exc_opcode = 0; exc_div0 = 0;
      chk("t2_cause", 32'(cause_out), 32'd0);
      step();
      chk("t2_addr", mem_addr, 32'd253);
      chk("t2_epc", epc_out, 32'h1FC);
      step(); step();
      chk_idle("t2_end");

      // 4: div0 with rfe -> exception wins
      exc_div0 = 1; rfe = 1; pc_in = 32'h300;
      step(); exc_div0 = 0; rfe = 0;
      chk("t4_cause", 32'(cause_out), 32'd2);
      chk("t4_psrc", 32'(pcsource), 32'd0);
      chk("t4_pcw", 32'(pc_write), 32'd0);
      step();
      chk("t4_addr", mem_addr, 32'd255);
      chk("t4_epc", epc_out, 32'h2FC);
      step();
      chk("t4_load_psrc", 32'(pcsource), 32'd4);
      step();
      chk_idle("t4_end");

      // 5: exception during FETCH ignored
      exc_ovf = 1; pc_in = 32'h400; pw_start = pw_cnt;
      step(); exc_ovf = 0;
      step();
      chk("t5_fetch_mrd", 32'(mem_read), 32'd1);
      exc_opcode = 1; pc_in = 32'h500;
      step(); exc_opcode = 0;
      chk("t5_load_pcw", 32'(pc_write), 32'd1);
      chk("t5_cause", 32'(cause_out), 32'd1);
      chk("t5_epc", epc_out, 32'h3FC);
      step(); step(); step();
      chk_idle("t5_end");
      chk("t5_cause_hold", 32'(cause_out), 32'd1);
      chk("t5_epc_hold", epc_out, 32'h3FC);
      chk("t5_pw_count", 32'(pw_cnt - pw_start), 32'd1);

      // 6: reset during FETCH, then exception with pc_in = 0
      exc_ovf = 1; pc_in = 32'h600; pw_start = pw_cnt;
      step(); exc_ovf = 0;
      step();
      chk("t6_fetch_mrd", 32'(mem_read), 32'd1);
      reset = 1;
      step(); reset = 0;
      chk_idle("t6_rst");
      chk("t6_rst_epc", epc_out, 32'd0);
      chk("t6_rst_cause", 32'(cause_out), 32'd0);
      chk("t6_rst_addr", mem_addr, 32'd0);
      step();
      chk("t6_no_pcw", 32'(pw_cnt - pw_start), 32'd0);
      exc_opcode = 1; pc_in = 32'h0;
      step(); exc_opcode = 0;
      step();
      chk("t6_epc_wrap", epc_out, 32'hFFFFFFFC);
      chk("t6_addr", mem_addr, 32'd253);
      step();
      chk("t6_load_pcw", 32'(pc_write), 32'd1);
      step();
      chk_idle("t6_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
